// File: rtl/dmac_burst_arbiter.sv
// dmac_burst_arbiter
//   Merges N_MASTER per-channel source streams onto a single destination
//   stream. The grant is held for a whole burst, which ends on a beat with
//   src_last_i set. Between bursts the next winner is chosen either by
//   round-robin (PRIORITY_MODE=0) or by fixed priority, where the lowest
//   index wins (PRIORITY_MODE=1). The output is one register stage that
//   sustains full throughput, and each beat carries the ID of its master.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   src_valid_i[i]   source i beat valid
//   src_ready_o[i]   source i beat accepted (combinational, one-hot or zero)
//   src_data_i[i]    source i data
//   src_last_i[i]    source i final beat of burst
//   dst_valid_o      registered beat valid
//   dst_ready_i      destination accepts beat
//   dst_data_o       registered data
//   dst_last_o       registered last flag
//   dst_id_o         index of the master that produced the beat
//   locked_o         burst in progress (grant held)
module dmac_burst_arbiter #(
  parameter int N_MASTER      = 4,
  parameter int DATA_SIZE     = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int ID_W          = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTER-1:0]  src_valid_i,
  output logic [N_MASTER-1:0]  src_ready_o,
  input  logic [DATA_SIZE-1:0] src_data_i [N_MASTER],
  input  logic [N_MASTER-1:0]  src_last_i,
  output logic                 dst_valid_o,
  input  logic                 dst_ready_i,
  output logic [DATA_SIZE-1:0] dst_data_o,
  output logic                 dst_last_o,
  output logic [ID_W-1:0]      dst_id_o,
  output logic                 locked_o
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_grant_id;
  logic                 r_dst_valid;
  logic [DATA_SIZE-1:0] r_dst_data;
  logic                 r_dst_last;
  logic [ID_W-1:0]      r_dst_id;

  logic [ID_W-1:0]      w_sel;
  logic                 w_sel_vld;
  logic                 w_load_en;
  logic                 w_xfer;
  logic                 w_sel_last;
  logic [ID_W-1:0]      w_rr_nxt;

  // Index of the k-th candidate in the round-robin scan starting at base.
  function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    if (sum >= N_MASTER) sum = sum - N_MASTER;
    return ID_W'(sum);
  endfunction

  // The output register can take a new beat when empty or being drained.
  assign w_load_en = !r_dst_valid || dst_ready_i;
  assign w_xfer    = w_load_en && w_sel_vld;
  assign w_sel_last = src_last_i[w_sel];
  assign w_rr_nxt  = (w_sel == ID_W'(N_MASTER - 1)) ? '0 : w_sel + ID_W'(1);

  // Winner selection. While locked only the granted master is considered,
  // even when it drops valid, so a burst is never interleaved.
  // NOTE: combinational blocks assign every output a default first; a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    w_sel     = '0;
    w_sel_vld = 1'b0;
    if (r_state == S_LOCKED) begin
      w_sel     = r_grant_id;
      w_sel_vld = src_valid_i[r_grant_id];
    end else if (PRIORITY_MODE == 1) begin
      // Scan downwards so the lowest valid index is the last one written.
      for (int i = N_MASTER - 1; i >= 0; i--) begin
        if (src_valid_i[i]) begin
          w_sel     = ID_W'(i);
          w_sel_vld = 1'b1;
        end
      end
    end else begin
      // Same trick, relative to rr_ptr: the first valid in scan order wins.
      for (int k = N_MASTER - 1; k >= 0; k--) begin
        if (src_valid_i[wrap_idx(int'(r_rr_ptr), k)]) begin
          w_sel     = wrap_idx(int'(r_rr_ptr), k);
          w_sel_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    src_ready_o = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      src_ready_o[i] = w_xfer && (w_sel == ID_W'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = w_sel_last ? S_IDLE : S_LOCKED;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_dst_valid <= 1'b0;
      r_dst_data  <= '0;
      r_dst_last  <= 1'b0;
      r_dst_id    <= '0;
    end else if (w_load_en) begin
      r_dst_valid <= w_xfer;
      if (w_xfer) begin
        r_dst_data <= src_data_i[w_sel];
        r_dst_last <= w_sel_last;
        r_dst_id   <= w_sel;
        if (w_sel_last) begin
          r_rr_ptr <= w_rr_nxt;
        end else begin
          r_grant_id <= w_sel;
        end
      end
    end
  end

  assign dst_valid_o = r_dst_valid;
  assign dst_data_o  = r_dst_data;
  assign dst_last_o  = r_dst_last;
  assign dst_id_o    = r_dst_id;
  assign locked_o    = (r_state == S_LOCKED);

endmodule
